pipe_stage_elastic: RTL

//  - Parametrised inter-stage pipeline register for the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Replaces hand-written per-stage registers with a valid/ready elastic stage.
//  - Supports multi-source flush (jump, bubble, interrupt, eret) and stall back-pressure.
//  - Carries a control bundle forced to zero in bubbles, so a killed slot never writes a register or memory.
//  - Provides saturating stall and flush statistics counters.

---
 rtl/pipe_stage_elastic.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready inter-stage pipeline register with flush, bubble zeroing and stall/flush counters.
// Optional 1-entry skid buffer enabled by defining PIPE_SKID_EN (registered in_ready).
module pipe_stage_elastic #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 24,
  parameter int FLUSH_N = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLUSH_N-1:0] flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              flush_any;
  logic              main_free;
  logic              held_valid;

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  assign flush_any = |flush;
  assign main_free = out_ready | ~out_valid_q;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign in_ready   = ~skid_valid_q;
  assign held_valid = out_valid_q | skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush_any) begin
      out_valid_d  = 1'b0;
      out_ctrl_d   = '0;
      out_data_d   = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Skid is older than anything on the input; input is blocked while skid is full.
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = in_ctrl;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
        out_ctrl_d  = '0;
      end
    end else if (in_valid & ~skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready   = main_free;
  assign held_valid = out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    if (flush_any) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
      out_data_d  = '0;
    end else if (main_free) begin
      if (in_valid) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = in_ctrl;
        out_data_d  = in_data;
      end else begin
        // Bubble: payload is left as-is, only the control bundle is killed.
        out_valid_d = 1'b0;
        out_ctrl_d  = '0;
      end
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q & ~out_ready & ~(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_any & held_valid & ~(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
